// File: rtl/motor_fb_scheduler_pkg.sv
// Shared types and default parameters for the motor feedback scheduler.
// Optional build macro used by the scheduler: MOTOR_FB_OVERRUN_CNT_EN.
package motor_fb_pkg;

  typedef logic signed [15:0] rpm_t;

  localparam int   NUM_MOT_DEF  = 4;
  localparam rpm_t RPM_MAX_DEF  = 16'sh157C;
  localparam int   FB_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/motor_fb_scheduler_if.sv
// Bus between the flight-control loop / motor model (master) and the
// motor feedback scheduler (slave).
// MOTOR_FB_OVERRUN_CNT_EN adds overrun_clr / overrun_cnt.
interface motor_fb_scheduler_if
  import motor_fb_pkg::*;
#(
  parameter int NUM_MOT = NUM_MOT_DEF
) ();

  logic               tick;
  logic [NUM_MOT-1:0] set_req;
  rpm_t               set_rpm   [NUM_MOT];
  rpm_t               mot_rpm   [NUM_MOT];
  logic [NUM_MOT-1:0] set_ack;
  rpm_t               rpm_sense [NUM_MOT];
  logic               busy;
  logic               sweep_done;
`ifdef MOTOR_FB_OVERRUN_CNT_EN
  logic               overrun_clr;
  logic [7:0]         overrun_cnt;

  modport master (
    output tick, set_req, set_rpm, mot_rpm, overrun_clr,
    input  set_ack, rpm_sense, busy, sweep_done, overrun_cnt
  );

  modport slave (
    input  tick, set_req, set_rpm, mot_rpm, overrun_clr,
    output set_ack, rpm_sense, busy, sweep_done, overrun_cnt
  );
`else
  modport master (
    output tick, set_req, set_rpm, mot_rpm,
    input  set_ack, rpm_sense, busy, sweep_done
  );

  modport slave (
    input  tick, set_req, set_rpm, mot_rpm,
    output set_ack, rpm_sense, busy, sweep_done
  );
`endif

endinterface

// File: rtl/motor_fb_scheduler_calc.sv
// Shared feedback datapath: adds the scaled previous motor rpm to the
// current sensed rpm (16-bit wrap) and clamps the result to [0, RPM_MAX].
module motor_fb_calc
  import motor_fb_pkg::*;
#(
  parameter rpm_t RPM_MAX  = RPM_MAX_DEF,
  parameter int   FB_SHIFT = FB_SHIFT_DEF
) (
  input  rpm_t cur_i,
  input  rpm_t old_i,
  output rpm_t next_o
);

  rpm_t sum;

  // Wrapping sum followed by saturation; a wrapped negative sum clamps to 0
  always_comb begin
    sum = cur_i + (old_i >>> FB_SHIFT);
    if (sum >= RPM_MAX) begin
      next_o = RPM_MAX;
    end else if (sum <= 16'sd0) begin
      next_o = 16'sd0;
    end else begin
      next_o = sum;
    end
  end

endmodule

// File: rtl/motor_fb_scheduler.sv
// Time-multiplexed motor feedback scheduler: on each tick, sweeps the
// motor channels one per cycle through a single shared calc datapath and
// applies pending per-channel set requests in each channel's slot.
// Optional build macro: MOTOR_FB_OVERRUN_CNT_EN (counts ticks ignored while busy).
module motor_fb_scheduler
  import motor_fb_pkg::*;
#(
  parameter int   NUM_MOT  = NUM_MOT_DEF,
  parameter rpm_t RPM_MAX  = RPM_MAX_DEF,
  parameter int   FB_SHIFT = FB_SHIFT_DEF
) (
  input logic                 clk,
  input logic                 resetn,
  motor_fb_scheduler_if.slave bus
);

  localparam int                 IDX_W    = $clog2(NUM_MOT);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_MOT - 1);
  localparam logic [NUM_MOT-1:0] ACK_ONE  = NUM_MOT'(1);

  fsm_state_t         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_MOT-1:0] set_ack_q;
  logic               busy_q;
  logic               sweep_done_q;

  rpm_t rpm_sense_w [NUM_MOT];
  rpm_t old_rpm_w   [NUM_MOT];
  rpm_t cur_sel;
  rpm_t old_sel;
  logic req_sel;
  rpm_t calc_next;

  // Select the channel currently owning the shared datapath
  always_comb begin
    cur_sel = '0;
    old_sel = '0;
    req_sel = 1'b0;
    for (int i = 0; i < NUM_MOT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_sel = rpm_sense_w[i];
        old_sel = old_rpm_w[i];
        req_sel = bus.set_req[i];
      end
    end
  end

  motor_fb_calc #(
    .RPM_MAX  (RPM_MAX),
    .FB_SHIFT (FB_SHIFT)
  ) u_calc (
    .cur_i  (cur_sel),
    .old_i  (old_sel),
    .next_o (calc_next)
  );

  // Sweep FSM with registered busy / sweep_done / set_ack outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      set_ack_q    <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      set_ack_q    <= '0;
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.tick) begin
            state_q <= UPDATE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        UPDATE: begin
          if (req_sel) begin
            set_ack_q <= ACK_ONE << idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q      <= DONE;
            sweep_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_MOT; gi++) begin : g_chan
    logic slot_en;
    rpm_t rpm_sense_q;
    rpm_t rpm_sense_d;
    rpm_t old_rpm_q;
    rpm_t old_rpm_d;

    assign slot_en = (state_q == UPDATE) && (idx_q == IDX_W'(gi));

    // Channel state only changes in its own slot; a set request wins over feedback
    always_comb begin
      rpm_sense_d = rpm_sense_q;
      old_rpm_d   = old_rpm_q;
      if (slot_en) begin
        if (bus.set_req[gi]) begin
          rpm_sense_d = bus.set_rpm[gi];
          old_rpm_d   = '0;
        end else begin
          rpm_sense_d = calc_next;
          old_rpm_d   = bus.mot_rpm[gi];
        end
      end
    end

    // Per-channel state registers
    always_ff @(posedge clk) begin
      if (!resetn) begin
        rpm_sense_q <= '0;
        old_rpm_q   <= '0;
      end else begin
        rpm_sense_q <= rpm_sense_d;
        old_rpm_q   <= old_rpm_d;
      end
    end

    assign rpm_sense_w[gi]   = rpm_sense_q;
    assign old_rpm_w[gi]     = old_rpm_q;
    assign bus.rpm_sense[gi] = rpm_sense_q;
  end

  assign bus.set_ack    = set_ack_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;

`ifdef MOTOR_FB_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q;

  // Count ticks dropped because a sweep is in flight; clear has priority
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_cnt_q <= '0;
    end else if (bus.overrun_clr) begin
      overrun_cnt_q <= '0;
    end else if (bus.tick && (state_q != IDLE) && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_q <= overrun_cnt_q + 8'd1;
    end
  end

  assign bus.overrun_cnt = overrun_cnt_q;
`endif

endmodule
